// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the 1-to-N serial-to-parallel deserializer.
//   DESER_WIDTH_DEFAULT : default word width in bits
//   bit_order_e         : first-received-bit placement (LSB or MSB of the word)
//   idx_w()             : width of the bit-index counter for a given word width
//   last_idx()          : index of the final bit of a word
// -----------------------------------------------------------------------------
package deser_pkg;

    localparam int DESER_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        BO_LSB_FIRST = 1'b0,
        BO_MSB_FIRST = 1'b1
    } bit_order_e;

    function automatic int idx_w(input int width);
        return $clog2(width);
    endfunction

    function automatic int last_idx(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/deser_shift.sv
// -----------------------------------------------------------------------------
// deser_shift
// Shift register, bit counter and word-alignment (sync) handling.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   din, din_valid    : serial bit and its qualifier
//   sync              : marks the current qualified bit as bit 0 of a new word
//   bit_idx           : index of the next expected bit (registered)
//   word              : current shift contents merged with the incoming bit
//   word_done         : strobe, the incoming bit completes a word this cycle
// word/word_done are combinational and must only feed registers in the parent.
// -----------------------------------------------------------------------------
module deser_shift
    import deser_pkg::*;
#(
    parameter int WIDTH     = DESER_WIDTH_DEFAULT,
    parameter int MSB_FIRST = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      din_valid,
    input  logic                      sync,
    output logic [idx_w(WIDTH)-1:0]   bit_idx,
    output logic [WIDTH-1:0]          word,
    output logic                      word_done
);

    localparam int         IDX_W    = idx_w(WIDTH);
    localparam int         LAST_IDX = last_idx(WIDTH);
    localparam bit_order_e ORDER    = (MSB_FIRST != 0) ? BO_MSB_FIRST : BO_LSB_FIRST;

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] eff_idx_s;
    logic [IDX_W-1:0] pos_s;
    logic [WIDTH-1:0] base_s;
    logic             done_s;

    // Slot for the incoming bit: sync restarts at slot 0; MSB-first mirrors the slot.
    always_comb begin
        if (sync) begin
            eff_idx_s = {IDX_W{1'b0}};
        end else begin
            eff_idx_s = idx_q;
        end
        if (ORDER == BO_MSB_FIRST) begin
            pos_s = IDX_W'(LAST_IDX) - eff_idx_s;
        end else begin
            pos_s = eff_idx_s;
        end
    end

    // Merge the incoming bit; a sync bit starts from an empty word so the partial word is lost.
    always_comb begin
        if (sync) begin
            base_s = {WIDTH{1'b0}};
        end else begin
            base_s = shift_q;
        end
        base_s[pos_s] = din;
    end

    // Next state: advance on qualified bits, wrap and flag completion on the last slot.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        done_s  = 1'b0;
        if (din_valid) begin
            if (eff_idx_s == IDX_W'(LAST_IDX)) begin
                done_s  = 1'b1;
                idx_d   = {IDX_W{1'b0}};
                shift_d = {WIDTH{1'b0}};
            end else begin
                idx_d   = eff_idx_s + IDX_W'(1);
                shift_d = base_s;
            end
        end else begin
            shift_d = shift_q;
            idx_d   = idx_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= {WIDTH{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign bit_idx   = idx_q;
    assign word      = base_s;
    assign word_done = done_s;

endmodule

// File: rtl/deser_1to8.sv
// -----------------------------------------------------------------------------
// deser_1to8
// Serial-to-parallel deserializer with a valid/ready holding register.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   din, din_valid : serial bit and qualifier (no serial backpressure)
//   sync           : with din_valid, marks bit 0 of a new word
//   bit_idx        : next expected bit index (matches the far-end mux sel)
//   dataout        : assembled word, stable while dataout_valid=1
//   dataout_valid  : holding register full
//   dataout_ready  : consumer accepts when dataout_valid & dataout_ready
// Optional (macro DESER_1TO8_OVERRUN_EN):
//   overrun_clr    : clears the sticky overrun flag
//   overrun        : sticky, set after a word is dropped because the holding
//                    register was full and not being accepted
// All outputs are registered.
// -----------------------------------------------------------------------------
module deser_1to8
    import deser_pkg::*;
#(
    parameter int WIDTH     = DESER_WIDTH_DEFAULT,
    parameter int MSB_FIRST = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    input  logic                      din_valid,
    input  logic                      sync,
    output logic [idx_w(WIDTH)-1:0]   bit_idx,
    output logic [WIDTH-1:0]          dataout,
    output logic                      dataout_valid,
    input  logic                      dataout_ready
`ifdef DESER_1TO8_OVERRUN_EN
    ,
    input  logic                      overrun_clr,
    output logic                      overrun
`endif
);

    logic [WIDTH-1:0] word_s;
    logic             word_done_s;
    logic             accept_s;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;

    deser_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .bit_idx   (bit_idx),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // Holding register: load on completion when empty or being drained; otherwise keep the old word.
    always_comb begin
        dout_d   = dout_q;
        valid_d  = valid_q;
        accept_s = valid_q & dataout_ready;
        if (word_done_s && (!valid_q || accept_s)) begin
            dout_d  = word_s;
            valid_d = 1'b1;
        end else if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dataout       = dout_q;
    assign dataout_valid = valid_q;

`ifdef DESER_1TO8_OVERRUN_EN
    logic drop_s;
    logic overrun_q;
    logic overrun_d;

    assign drop_s = word_done_s & valid_q & ~dataout_ready;

    // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
    always_comb begin
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Overrun flag state.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_deser_1to8.sv
// -----------------------------------------------------------------------------
// tb_deser_1to8
// Self-checking bench: inst0 is LSB-first, inst1 is MSB-first (its din_valid is
// gated so it only sees the final test). Expected words are queued when the
// last bit is driven and compared when the consumer accepts a word.
// -----------------------------------------------------------------------------
module tb_deser_1to8;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       sync;
    logic       ready;
    logic       en1;
    logic       din_valid1;

    logic [2:0] bit_idx0;
    logic [2:0] bit_idx1;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic       dv0;
    logic       dv1;
`ifdef DESER_1TO8_OVERRUN_EN
    logic       overrun_clr;
    logic       overrun0;
    logic       overrun1;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    typedef struct {
        logic [7:0] word;
        int         gap_at;
        int         gap_len;
        logic [7:0] expect_word;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign din_valid1 = din_valid & en1;

    deser_1to8 #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .din_valid     (din_valid),
        .sync          (sync),
        .bit_idx       (bit_idx0),
        .dataout       (dout0),
        .dataout_valid (dv0),
        .dataout_ready (ready)
`ifdef DESER_1TO8_OVERRUN_EN
        ,
        .overrun_clr   (overrun_clr),
        .overrun       (overrun0)
`endif
    );

    deser_1to8 #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .din_valid     (din_valid1),
        .sync          (sync),
        .bit_idx       (bit_idx1),
        .dataout       (dout1),
        .dataout_valid (dv1),
        .dataout_ready (ready)
`ifdef DESER_1TO8_OVERRUN_EN
        ,
        .overrun_clr   (overrun_clr),
        .overrun       (overrun1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every accepted word against the queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (dv0 && ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word0: got %0h expected none", dout0);
                end else begin
                    check("word0", {24'd0, dout0}, {24'd0, q0.pop_front()});
                end
            end
            if (dv1 && ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word1: got %0h expected none", dout1);
                end else begin
                    check("word1", {24'd0, dout1}, {24'd0, q1.pop_front()});
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic s);
        din       = b;
        sync      = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
        din       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends w LSB-first; optionally queues the expected word just before the last bit.
    task automatic send_word(input logic [7:0] w, input logic [7:0] exp0, input bit push0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && push0) begin
                q0.push_back(exp0);
            end
            send_bit(w[i], 1'b0);
        end
    endtask

    initial begin
        logic [7:0] w;

        vecs[0] = '{word: 8'hA5, gap_at: 8, gap_len: 0, expect_word: 8'hA5};
        vecs[1] = '{word: 8'hA5, gap_at: 4, gap_len: 3, expect_word: 8'hA5};
        vecs[2] = '{word: 8'h00, gap_at: 8, gap_len: 0, expect_word: 8'h00};
        vecs[3] = '{word: 8'hFF, gap_at: 2, gap_len: 1, expect_word: 8'hFF};
        vecs[4] = '{word: 8'h5A, gap_at: 7, gap_len: 2, expect_word: 8'h5A};

        reset     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sync      = 1'b0;
        ready     = 1'b1;
        en1       = 1'b0;
`ifdef DESER_1TO8_OVERRUN_EN
        overrun_clr = 1'b0;
`endif
        idle(2);
        reset = 1'b0;

        // Reset state
        check("rst_bit_idx0", {29'd0, bit_idx0}, 32'd0);
        check("rst_valid0",   {31'd0, dv0},      32'd0);
        check("rst_dataout0", {24'd0, dout0},    32'd0);
        check("rst_bit_idx1", {29'd0, bit_idx1}, 32'd0);
        check("rst_valid1",   {31'd0, dv1},      32'd0);
`ifdef DESER_1TO8_OVERRUN_EN
        check("rst_overrun0", {31'd0, overrun0}, 32'd0);
`endif

        // Table-driven words with ready high and optional din_valid gaps
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) begin
                if (i == vecs[v].gap_at) begin
                    for (int g = 0; g < vecs[v].gap_len; g++) begin
                        idle(1);
                        check("gap_bit_idx", {29'd0, bit_idx0}, i);
                    end
                end
                check("bit_idx_seq", {29'd0, bit_idx0}, i);
                if (i == 7) begin
                    q0.push_back(vecs[v].expect_word);
                end
                send_bit(vecs[v].word[i], 1'b0);
            end
            check("done_valid_lat1", {31'd0, dv0},      32'd1);
            check("done_bit_idx",    {29'd0, bit_idx0}, 32'd0);
            check("done_dataout",    {24'd0, dout0},    {24'd0, vecs[v].expect_word});
            idle(1);
            check("valid_one_cycle", {31'd0, dv0},      32'd0);
        end

        // Three stray bits, then a sync-aligned 0x3C: only 0x3C may appear
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("pre_sync_idx", {29'd0, bit_idx0}, 32'd3);
        w = 8'h3C;
        send_bit(w[0], 1'b1);
        check("sync_idx", {29'd0, bit_idx0}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            if (i == 7) begin
                q0.push_back(8'h3C);
            end
            send_bit(w[i], 1'b0);
        end
        check("sync_dataout", {24'd0, dout0}, 32'h3C);
        idle(2);

        // Overrun: consumer stalled, second word dropped, first kept
        ready = 1'b0;
        send_word(8'h11, 8'h11, 1'b1);
        check("ovr_first_valid", {31'd0, dv0}, 32'd1);
`ifdef DESER_1TO8_OVERRUN_EN
        check("ovr_not_yet", {31'd0, overrun0}, 32'd0);
`endif
        send_word(8'h22, 8'h00, 1'b0);
        check("ovr_hold_data",  {24'd0, dout0}, 32'h11);
        check("ovr_hold_valid", {31'd0, dv0},   32'd1);
`ifdef DESER_1TO8_OVERRUN_EN
        check("ovr_set", {31'd0, overrun0}, 32'd1);
`endif
        ready = 1'b1;
        idle(1);
        check("ovr_drained", {31'd0, dv0}, 32'd0);
        idle(1);
        check("ovr_no_second", {31'd0, dv0}, 32'd0);
`ifdef DESER_1TO8_OVERRUN_EN
        check("ovr_sticky", {31'd0, overrun0}, 32'd1);
        overrun_clr = 1'b1;
        idle(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", {31'd0, overrun0}, 32'd0);
`endif

        // Completion coinciding with accept: 0x66 taken, 0x77 loaded, valid stays high
        ready = 1'b0;
        send_word(8'h66, 8'h66, 1'b1);
        w = 8'h77;
        for (int i = 0; i < 7; i++) begin
            send_bit(w[i], 1'b0);
        end
        check("sim_held_valid", {31'd0, dv0},   32'd1);
        check("sim_held_data",  {24'd0, dout0}, 32'h66);
        ready = 1'b1;
        q0.push_back(8'h77);
        send_bit(w[7], 1'b0);
        ready = 1'b0;
        check("sim_valid_stays", {31'd0, dv0},   32'd1);
        check("sim_new_data",    {24'd0, dout0}, 32'h77);
`ifdef DESER_1TO8_OVERRUN_EN
        check("sim_no_overrun", {31'd0, overrun0}, 32'd0);
`endif
        ready = 1'b1;
        idle(1);
        check("sim_drained", {31'd0, dv0}, 32'd0);

        // Reset mid-word on both orderings, then 1,1,1,1,0,0,0,0
        en1 = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("mid_idx0", {29'd0, bit_idx0}, 32'd5);
        check("mid_idx1", {29'd0, bit_idx1}, 32'd5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_valid0", {31'd0, dv0},      32'd0);
        check("mid_rst_data0",  {24'd0, dout0},    32'd0);
        check("mid_rst_idx0",   {29'd0, bit_idx0}, 32'd0);
        check("mid_rst_idx1",   {29'd0, bit_idx1}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                q0.push_back(8'h0F);
                q1.push_back(8'hF0);
            end
            send_bit((i < 4) ? 1'b1 : 1'b0, 1'b0);
        end
        check("msb_valid1", {31'd0, dv1},   32'd1);
        check("msb_data1",  {24'd0, dout1}, 32'hF0);
        check("lsb_data0",  {24'd0, dout0}, 32'h0F);
        en1 = 1'b0;
        idle(3);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
